// File: rtl/udp_tx_sched.sv
// Round-robin scheduler granting the UDP send interface to one of two RTP packet sources.
// Optional macro UDP_TX_SCHED_TIMEOUT_EN adds a ready timeout while waiting in START.
module udp_tx_sched #(
    parameter int unsigned MAX_LEN       = 1472,
    parameter int unsigned GAP_CYCLES    = 12,
    parameter int unsigned READY_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  src_req,
    input  logic [15:0] src_len0,
    input  logic [15:0] src_len1,
    input  logic [7:0]  src_data0,
    input  logic [7:0]  src_data1,
    output logic [1:0]  src_rd,
    output logic [1:0]  src_done,
    output logic [1:0]  src_err,
    output logic        udp_send_data_valid,
    input  logic        udp_send_data_ready,
    output logic [15:0] udp_send_data_length,
    input  logic        udp_tx_req,
    output logic [7:0]  udp_tx_data,
    output logic [1:0]  grant
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_STREAM,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          owner;
    logic          winner;
    logic          end_pkt;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
    localparam int unsigned TW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`else
    logic ready_timeout_unused;
    assign ready_timeout_unused = (READY_TIMEOUT == 0);
`endif

    assign owner                = grant_q[1];
    assign grant                = grant_q;
    assign udp_send_data_length = len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        last_grant_d        = last_grant_q;
        len_d               = len_q;
        byte_cnt_d          = byte_cnt_q;
        gap_cnt_d           = gap_cnt_q;
        winner              = 1'b0;
        end_pkt             = 1'b0;
        src_rd              = '0;
        src_done            = '0;
        src_err             = '0;
        udp_send_data_valid = 1'b0;
        udp_tx_data         = '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
        to_cnt_d            = to_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (|src_req) begin
                    // on a tie the source that did not go last wins
                    winner     = (src_req == 2'b11) ? ~last_grant_q : src_req[1];
                    grant_d    = winner ? 2'b10 : 2'b01;
                    len_d      = winner ? src_len1 : src_len0;
                    byte_cnt_d = '0;
                    state_d    = S_CHECK;
                end
            end

            S_CHECK: begin
                if (len_q == '0 || 32'(len_q) > MAX_LEN) begin
                    src_done[owner] = 1'b1;
                    src_err[owner]  = 1'b1;
                    end_pkt         = 1'b1;
                end else begin
                    state_d = S_START;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end

            S_START: begin
                udp_send_data_valid = 1'b1;
                if (udp_send_data_ready) begin
                    state_d = S_STREAM;
                end
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                else if (to_cnt_q == TW'(READY_TIMEOUT - 1)) begin
                    src_done[owner] = 1'b1;
                    src_err[owner]  = 1'b1;
                    end_pkt         = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end

            S_STREAM: begin
                udp_tx_data   = owner ? src_data1 : src_data0;
                src_rd[owner] = udp_tx_req;
                if (udp_tx_req) begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (byte_cnt_q == len_q - 16'd1) begin
                        src_done[owner] = 1'b1;
                        end_pkt         = 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        // sent, dropped and timed-out packets all share the same exit path
        if (end_pkt) begin
            last_grant_d = owner;
            gap_cnt_d    = '0;
            if (GAP_CYCLES == 0) begin
                state_d = S_IDLE;
                grant_d = '0;
            end else begin
                state_d = S_GAP;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed self-checking bench for udp_tx_sched in its default configuration.
module tb_udp_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_req;
    logic [15:0] src_len0, src_len1;
    logic [7:0]  src_data0, src_data1;
    logic [1:0]  src_rd, src_done, src_err;
    logic        udp_send_data_valid, udp_send_data_ready;
    logic [15:0] udp_send_data_length;
    logic        udp_tx_req;
    logic [7:0]  udp_tx_data;
    logic [1:0]  grant;

    udp_tx_sched #(
        .MAX_LEN(1472),
        .GAP_CYCLES(12),
        .READY_TIMEOUT(4096)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_req(src_req),
        .src_len0(src_len0),
        .src_len1(src_len1),
        .src_data0(src_data0),
        .src_data1(src_data1),
        .src_rd(src_rd),
        .src_done(src_done),
        .src_err(src_err),
        .udp_send_data_valid(udp_send_data_valid),
        .udp_send_data_ready(udp_send_data_ready),
        .udp_send_data_length(udp_send_data_length),
        .udp_tx_req(udp_tx_req),
        .udp_tx_data(udp_tx_data),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          cyc, vcnt, first_v, rd0, rd1, rd_bad, data_bad;
    int          done_cyc, first_done, idle_cyc;
    int          done_n [2];
    int          err_n  [2];
    int          done_seq[$];
    logic [15:0] len_seen;
    logic [7:0]  idx0 = 8'd0;
    logic [7:0]  idx1 = 8'd0;
    logic [7:0]  exp_b;
    bit          auto_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; vcnt = 0; first_v = -1; rd0 = 0; rd1 = 0; rd_bad = 0; data_bad = 0;
        done_cyc = -1; first_done = -1; idle_cyc = -1; len_seen = '0;
        done_n[0] = 0; done_n[1] = 0; err_n[0] = 0; err_n[1] = 0;
        done_seq.delete();
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_grant"}, 32'(grant), 32'd0);
        check({pfx, "_ctl"}, 32'({udp_send_data_valid, src_rd, src_done, src_err}), 32'd0);
        check({pfx, "_data"}, 32'(udp_tx_data), 32'd0);
    endtask

    // Called at a negedge with this cycle's inputs applied; returns at the next negedge.
    task automatic cycle();
        #1;
        if (udp_send_data_valid) begin
            if (first_v < 0) first_v = cyc;
            vcnt++;
            len_seen = udp_send_data_length;
        end
        if (src_rd[0]) begin
            rd0++;
            exp_b = 8'hA0 + idx0;
            if (udp_tx_data !== exp_b) data_bad++;
        end
        if (src_rd[1]) begin
            rd1++;
            exp_b = 8'hB0 + idx1;
            if (udp_tx_data !== exp_b) data_bad++;
        end
        if ((src_rd != 2'b00 && !udp_tx_req) || src_rd == 2'b11) rd_bad++;
        for (int i = 0; i < 2; i++) begin
            if (src_done[i]) begin
                done_n[i]++;
                done_seq.push_back(i);
                done_cyc = cyc;
                if (first_done < 0) first_done = cyc;
                if (auto_drop) src_req[i] = 1'b0;
            end
            if (src_err[i]) err_n[i]++;
        end
        if (done_cyc >= 0 && idle_cyc < 0 && cyc > done_cyc && grant == 2'b00) idle_cyc = cyc;
        if (src_rd[0]) idx0 = idx0 + 8'd1;
        if (src_rd[1]) idx1 = idx1 + 8'd1;
        @(negedge clk);
        src_data0 = 8'hA0 + idx0;
        src_data1 = 8'hB0 + idx1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_req = '0;
        udp_send_data_ready = 1'b0;
        udp_tx_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs_zero("rst");
        check("rst_len", 32'(udp_send_data_length), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int drop_lens [3] = '{0, 1500, 1473};

    initial begin
        src_len0 = '0; src_len1 = '0;
        src_data0 = 8'hA0; src_data1 = 8'hB0;
        auto_drop = 1'b1;
        do_reset();

        // single source, 4 bytes, ready three cycles after valid
        clear_stats();
        src_req = 2'b01; src_len0 = 16'd4; udp_tx_req = 1'b1;
        for (int c = 0; c < 25; c++) begin
            udp_send_data_ready = (c == 5);
            if (c == 7) check("t1_grant_stream", 32'(grant), 32'd1);
            cycle();
        end
        check("t1_valid_cycles", 32'(vcnt), 32'd4);
        check("t1_first_valid", 32'(first_v), 32'd2);
        check("t1_length", 32'(len_seen), 32'd4);
        check("t1_rd0", 32'(rd0), 32'd4);
        check("t1_rd1", 32'(rd1), 32'd0);
        check("t1_data", 32'(data_bad), 32'd0);
        check("t1_done0", 32'(done_n[0]), 32'd1);
        check("t1_done_cyc", 32'(done_cyc), 32'd9);
        check("t1_err", 32'(err_n[0] + err_n[1]), 32'd0);
        check("t1_idle_cyc", 32'(idle_cyc), 32'd22);

        // both sources request continuously: strict alternation starting at source 0
        do_reset();
        clear_stats();
        auto_drop = 1'b0;
        src_req = 2'b11; src_len0 = 16'd2; src_len1 = 16'd2;
        udp_send_data_ready = 1'b1; udp_tx_req = 1'b1;
        for (int c = 0; c < 80; c++) cycle();
        src_req = 2'b00;
        for (int c = 0; c < 12; c++) cycle();
        check("t2_packets", 32'(done_seq.size()), 32'd5);
        check("t2_order0", 32'(done_seq[0]), 32'd0);
        check("t2_order1", 32'(done_seq[1]), 32'd1);
        check("t2_order2", 32'(done_seq[2]), 32'd0);
        check("t2_order3", 32'(done_seq[3]), 32'd1);
        check("t2_bytes", 32'(rd0 + rd1), 32'd10);
        check("t2_data", 32'(data_bad), 32'd0);
        check("t2_first_done", 32'(first_done), 32'd4);

        // illegal lengths are dropped without touching the UDP handshake
        auto_drop = 1'b1;
        udp_send_data_ready = 1'b0;
        foreach (drop_lens[k]) begin
            clear_stats();
            src_req = 2'b10; src_len1 = 16'(drop_lens[k]);
            for (int c = 0; c < 16; c++) cycle();
            check($sformatf("t3_len%0d_valid", drop_lens[k]), 32'(vcnt), 32'd0);
            check($sformatf("t3_len%0d_done", drop_lens[k]), 32'(done_n[1]), 32'd1);
            check($sformatf("t3_len%0d_err", drop_lens[k]), 32'(err_n[1]), 32'd1);
            check($sformatf("t3_len%0d_done_cyc", drop_lens[k]), 32'(done_cyc), 32'd1);
            check($sformatf("t3_len%0d_idle_cyc", drop_lens[k]), 32'(idle_cyc), 32'd14);
            check($sformatf("t3_len%0d_rd", drop_lens[k]), 32'(rd1), 32'd0);
        end

        // toggling MAC requests, stray ready pulse during STREAM
        clear_stats();
        src_req = 2'b01; src_len0 = 16'd3;
        for (int c = 0; c < 22; c++) begin
            udp_tx_req = (c % 2 == 1);
            udp_send_data_ready = (c == 2) || (c == 4);
            cycle();
        end
        check("t4_rd0", 32'(rd0), 32'd3);
        check("t4_rd_bad", 32'(rd_bad), 32'd0);
        check("t4_data", 32'(data_bad), 32'd0);
        check("t4_valid_cycles", 32'(vcnt), 32'd1);
        check("t4_done_cyc", 32'(done_cyc), 32'd7);
        check("t4_err", 32'(err_n[0]), 32'd0);
        check("t4_idle_cyc", 32'(idle_cyc), 32'd20);

        // reset while streaming byte 2 of 10
        clear_stats();
        src_req = 2'b01; src_len0 = 16'd10;
        udp_send_data_ready = 1'b1; udp_tx_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) begin
                rst = 1'b1;
                src_req = 2'b00;
            end
            cycle();
        end
        rst = 1'b0;
        #1;
        check_outputs_zero("t5_after_rst");
        check("t5_no_done", 32'(done_n[0] + done_n[1]), 32'd0);
        check("t5_rd_before_rst", 32'(rd0), 32'd3);

        clear_stats();
        src_req = 2'b11; src_len0 = 16'd2; src_len1 = 16'd2;
        for (int c = 0; c < 40; c++) cycle();
        check("t5_packets", 32'(done_seq.size()), 32'd2);
        check("t5_tie_winner", 32'(done_seq[0]), 32'd0);
        check("t5_second", 32'(done_seq[1]), 32'd1);
        check("t5_first_done", 32'(first_done), 32'd4);
        check("t5_rd0", 32'(rd0), 32'd2);
        check("t5_rd1", 32'(rd1), 32'd2);
        check("t5_data", 32'(data_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Schedules the single UDP send interface between two RTP packet sources, e.g. a left/right or mic/line packetizer pair.
- Round-robin grants one packet at a time and drives the packet-start handshake (valid/ready/length) toward the UDP stack.
- Streams the granted source's bytes as the MAC requests them, then enforces a minimum inter-packet gap.
- Sits between the RTP packetizers and the UDP/IP transmit engine.

Parameters:
MAX_LEN, 1472, largest legal packet length in bytes; longer requests are dropped.
GAP_CYCLES, 12, idle cycles enforced after each packet; 0 means no gap.
READY_TIMEOUT, 4096, cycles to wait for udp_send_data_ready (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
src_req  in  2  per-source packet request; held high until that source's src_done
src_len0  in  16  source 0 packet length in bytes; stable while src_req[0] is high
src_len1  in  16  source 1 packet length in bytes
src_data0  in  8  source 0 current byte (first-word-fall-through)
src_data1  in  8  source 1 current byte
src_rd  out  2  byte pop strobe to the granted source
src_done  out  2  one-cycle pulse: packet sent or dropped
src_err  out  2  one-cycle pulse alongside src_done when the packet was dropped
udp_send_data_valid  out  1  packet-start request to the UDP stack
udp_send_data_ready  in  1  UDP stack accepts the packet start
udp_send_data_length  out  16  registered length of the granted packet
udp_tx_req  in  1  MAC byte request; one byte consumed per high cycle
udp_tx_data  out  8  byte to the MAC
grant  out  2  one-hot current owner; 0 when idle

Behaviour:
- Reset: state=IDLE; last_grant=1, so source 0 wins the first tie. All outputs are 0.
- Reset mid-packet aborts immediately. No src_done is pulsed.
- IDLE state:
  - Any src_req bit high: pick the winner, latch grant and length, go to CHECK next cycle.
  - Both bits high: grant the source that is not last_grant. Otherwise grant the single requester.
- CHECK state (1 cycle):
  - Length 0 or length > MAX_LEN: pulse src_done and src_err for the owner, then go to GAP.
  - Otherwise go to START.
- START state:
  - udp_send_data_valid=1; udp_send_data_length holds the latched length.
  - When udp_send_data_ready is sampled high, go to STREAM and drop valid on the next cycle.
  - Ready is ignored in every other state.
- STREAM state:
  - udp_tx_data = src_dataN of the owner (combinational mux).
  - src_rd[owner] = udp_tx_req (combinational); the other src_rd bit stays 0.
  - A 16-bit byte counter increments on each udp_tx_req.
  - On udp_tx_req with count == len-1: pulse src_done[owner], update last_grant, go to GAP.
  - udp_tx_req is ignored outside STREAM.
- GAP state:
  - Counts GAP_CYCLES cycles, then goes to IDLE, where grant is cleared.
  - With GAP_CYCLES=0, go directly to IDLE.
  - A dropped packet also updates last_grant and passes through GAP.
- Request handling:
  - Deassertion of src_req by the owner mid-packet is ignored; the packet completes.
  - A new request from the other source during a packet waits until IDLE.
- Min packet-to-packet latency: 2 cycles (IDLE→CHECK→START) plus ready wait, bytes, and GAP.

Optional Feature:
UDP_TX_SCHED_TIMEOUT_EN
- Defined: a counter runs in START. If READY_TIMEOUT cycles elapse without ready:
  - deassert valid, pulse src_done and src_err for the owner;
  - update last_grant and go to GAP.
- Undefined: START waits indefinitely; src_err only flags length errors.

Test Plan:
- Only src_req=01, len0=4, ready 3 cycles after valid, udp_tx_req held high:
  - valid high 4 cycles, length=4;
  - src_rd[0] high exactly 4 cycles, udp_tx_data follows src_data0;
  - src_done[0] on the 4th byte, then 12 gap cycles, grant=00.
- src_req=11 simultaneously after reset, len0=len1=2: order is src0 then src1. Keep both requesting for 4 packets: grants alternate 0,1,0,1.
- len1=0, then len1=1500 (MAX_LEN=1472): each gives src_done[1] and src_err[1] with valid never asserted, followed by GAP.
- udp_tx_req toggling 1,0,1,0 with len=3: src_rd pulses only on req-high cycles, done after 3rd pulse; ready pulse during STREAM has no effect.
- rst=1 asserted mid-STREAM at byte 2 of 10: next cycle all outputs 0, no src_done. A subsequent request restarts from byte count 0, and source 0 wins a tie.
- With UDP_TX_SCHED_TIMEOUT_EN and READY_TIMEOUT=8, ready held low: valid high exactly 8 cycles, then src_done and src_err pulse, GAP, and the pending other source is granted next.
